nibble_serial_subtractor: RTL and testbench

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

---
 rtl/nibble_serial_subtractor_if.sv | 25 ++
 rtl/nibble_serial_subtractor.sv | 116 +++++++++++
 tb/tb_nibble_serial_subtractor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// Request/result bundle for the nibble-serial subtractor.
// The master side drives the operands; the slave side returns busy/done and the results.
interface nibble_serial_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             B_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             B_out;
    logic             overflow;

    modport master (
        output start, num1, num2, B_in,
        input  busy, done, diff, B_out, overflow
    );

    modport slave (
        input  start, num1, num2, B_in,
        output busy, done, diff, B_out, overflow
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: computes num1 - num2 - B_in one nibble per clock, LSB nibble first.
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nibble_serial_subtractor_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CW+1:0]    bit_idx;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       nib_res;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        bit_idx  = {cnt_q, 2'b00};
        a_nib    = a_q[bit_idx +: 4];
        b_nib    = b_q[bit_idx +: 4];
        // Bit 4 of the widened difference is the borrow into the next nibble.
        nib_res  = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_q};

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d      = bus.num1;
                    b_d      = bus.num2;
                    borrow_d = bus.B_in;
                    cnt_d    = '0;
                    diff_d   = '0;
                    b_out_d  = 1'b0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                diff_d[bit_idx +: 4] = nib_res[3:0];
                borrow_d             = nib_res[4];
                if (cnt_q == LAST_NIB) begin
                    // nib_res[3] is the final MSB of diff on the last nibble.
                    cnt_d   = '0;
                    b_out_d = nib_res[4];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (nib_res[3] != a_q[WIDTH-1]);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.B_out    = b_out_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor (WIDTH=32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_nibble_serial_subtractor;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    nibble_serial_subtractor_if #(.WIDTH(WIDTH)) bus_if ();

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents a request for one edge, then scrambles the operands to prove they were latched.
    task automatic applyStimulus(input string tag, input logic [31:0] n1, input logic [31:0] n2, input logic bin);
        bus_if.start = 1'b1;
        bus_if.num1  = n1;
        bus_if.num2  = n2;
        bus_if.B_in  = bin;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.num1  = ~n1;
        bus_if.num2  = n2 ^ 32'h5A5A_A5A5;
        bus_if.B_in  = ~bin;
        checkOutput({tag, ".acc_busy"}, {31'd0, bus_if.busy}, 32'd1);
        checkOutput({tag, ".acc_diff"}, bus_if.diff, 32'd0);
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus_if.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic checkResult(input string tag, input logic [31:0] ed, input logic eb, input logic eo);
        checkOutput({tag, ".diff"}, bus_if.diff, ed);
        checkOutput({tag, ".B_out"}, {31'd0, bus_if.B_out}, {31'd0, eb});
        checkOutput({tag, ".overflow"}, {31'd0, bus_if.overflow}, {31'd0, eo});
        checkOutput({tag, ".busy_at_done"}, {31'd0, bus_if.busy}, 32'd0);
    endtask

    task automatic runOp(input string tag, input logic [31:0] n1, input logic [31:0] n2, input logic bin,
                         input logic [31:0] ed, input logic eb, input logic eo);
        int lat;
        applyStimulus(tag, n1, n2, bin);
        waitDone(lat);
        checkOutput({tag, ".latency"}, lat, 32'd8);
        checkResult(tag, ed, eb, eo);
        @(negedge clk);
        checkOutput({tag, ".done_drop"}, {31'd0, bus_if.done}, 32'd0);
        checkOutput({tag, ".hold_diff"}, bus_if.diff, ed);
        checkOutput({tag, ".hold_B_out"}, {31'd0, bus_if.B_out}, {31'd0, eb});
    endtask

    initial begin
        int lat;
        int done_seen;

        rst_n        = 1'b0;
        bus_if.start = 1'b1;
        bus_if.num1  = 32'hDEAD_BEEF;
        bus_if.num2  = 32'h1;
        bus_if.B_in  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst.busy", {31'd0, bus_if.busy}, 32'd0);
        checkOutput("rst.done", {31'd0, bus_if.done}, 32'd0);
        checkOutput("rst.diff", bus_if.diff, 32'd0);
        checkOutput("rst.B_out", {31'd0, bus_if.B_out}, 32'd0);
        checkOutput("rst.overflow", {31'd0, bus_if.overflow}, 32'd0);
        bus_if.start = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        checkOutput("idle.busy", {31'd0, bus_if.busy}, 32'd0);

        runOp("small",   32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        runOp("wrap",    32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        runOp("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        runOp("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        runOp("eq_bin",  32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        runOp("pattern", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'h4B4B_4B4B, 1'b0, 1'b1);

        // Start during RUN is ignored; start held in DONE chains directly.
        applyStimulus("ign", 32'h0000_0010, 32'h0000_0001, 1'b0);
        repeat (2) @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.num1  = 32'hFFFF_FFFF;
        bus_if.num2  = 32'h0;
        @(negedge clk);
        bus_if.start = 1'b0;
        waitDone(lat);
        checkOutput("ign.latency_rest", lat, 32'd5);
        checkResult("ign", 32'h0000_000F, 1'b0, 1'b0);
        bus_if.start = 1'b1;
        bus_if.num1  = 32'h0000_0009;
        bus_if.num2  = 32'h0000_0004;
        bus_if.B_in  = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b0;
        checkOutput("b2b.busy", {31'd0, bus_if.busy}, 32'd1);
        checkOutput("b2b.done", {31'd0, bus_if.done}, 32'd0);
        checkOutput("b2b.acc_diff", bus_if.diff, 32'd0);
        waitDone(lat);
        checkOutput("b2b.latency", lat, 32'd8);
        checkResult("b2b", 32'h0000_0005, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("b2b.done_drop", {31'd0, bus_if.done}, 32'd0);

        // Reset mid-run aborts the operation with no done pulse.
        applyStimulus("abort", 32'h1234_5678, 32'h0000_0001, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort.busy", {31'd0, bus_if.busy}, 32'd0);
        checkOutput("abort.done", {31'd0, bus_if.done}, 32'd0);
        checkOutput("abort.diff", bus_if.diff, 32'd0);
        checkOutput("abort.overflow", {31'd0, bus_if.overflow}, 32'd0);
        rst_n     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_if.done) done_seen++;
        end
        checkOutput("abort.no_done", done_seen, 32'd0);
        runOp("after_rst", 32'h0000_0009, 32'h0000_0004, 1'b0, 32'h0000_0005, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
